// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and
// EX-stage operand forwarding from the EX/MEM and MEM/WB stages.
// Ports: clk_i/rst_ni (sync, active-low), flush_i/hold_i control,
//   id_* decoded instruction, mem_*/wb_* forwarding sources,
//   stall_o hazard request, ex_*/alu_op_o/operand_*_o EX bundle.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        id_valid_i,
  input  logic [3:0]  id_alu_op_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_imm_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_rd_wren_i,
  input  logic        id_mem_rden_i,
  input  logic        id_op_a_sel_i,
  input  logic        id_op_b_sel_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic        mem_rd_wren_i,
  input  logic [31:0] mem_fwd_data_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        wb_rd_wren_i,
  input  logic [31:0] wb_data_i,
  output logic        stall_o,
  output logic        ex_valid_o,
  output logic [3:0]  alu_op_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output logic [31:0] ex_store_data_o,
  output logic [4:0]  ex_rd_addr_o,
  output logic        ex_rd_wren_o,
  output logic        ex_mem_rden_o
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic        mem_rden;
    logic        op_a_sel;
    logic        op_b_sel;
  } id_ex_t;

  id_ex_t ex_q, ex_d, cap;

  logic wb_hit1, wb_hit2;
  logic use1, use2;

  // Register file write in the same cycle as its read:
  // take the WB value so the capture is not stale.
  assign wb_hit1 = wb_rd_wren_i
                 && (wb_rd_addr_i != 5'd0)
                 && (wb_rd_addr_i == id_rs1_addr_i);
  assign wb_hit2 = wb_rd_wren_i
                 && (wb_rd_addr_i != 5'd0)
                 && (wb_rd_addr_i == id_rs2_addr_i);

  always_comb begin
    cap          = '0;
    cap.valid    = 1'b1;
    cap.alu_op   = id_alu_op_i;
    cap.pc       = id_pc_i;
    cap.imm      = id_imm_i;
    cap.rs1_data = wb_hit1 ? wb_data_i : id_rs1_data_i;
    cap.rs2_data = wb_hit2 ? wb_data_i : id_rs2_data_i;
    cap.rs1_addr = id_rs1_addr_i;
    cap.rs2_addr = id_rs2_addr_i;
    cap.rd_addr  = id_rd_addr_i;
    cap.rd_wren  = id_rd_wren_i;
    cap.mem_rden = id_mem_rden_i;
    cap.op_a_sel = id_op_a_sel_i;
    cap.op_b_sel = id_op_b_sel_i;
  end

  assign use1 = ex_q.rd_addr == id_rs1_addr_i;
  assign use2 = ex_q.rd_addr == id_rs2_addr_i;

  assign stall_o = ex_q.valid
                && ex_q.mem_rden
                && (ex_q.rd_addr != 5'd0)
                && id_valid_i
                && !flush_i
                && !hold_i
                && (use1 || use2);

  always_comb begin
    ex_d = ex_q;
    priority case (1'b1)
      flush_i:     ex_d = '0;
      hold_i:      ex_d = ex_q;
      stall_o:     ex_d = '0;
      !id_valid_i: ex_d = '0;
      default:     ex_d = cap;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ex_q <= '0;
    else         ex_q <= ex_d;
  end

  function automatic logic [31:0] fwd(
    input logic [4:0]  a,
    input logic [31:0] r
  );
    if (mem_rd_wren_i && (mem_rd_addr_i != 5'd0)
        && (mem_rd_addr_i == a))
      return mem_fwd_data_i;
    if (wb_rd_wren_i && (wb_rd_addr_i != 5'd0)
        && (wb_rd_addr_i == a))
      return wb_data_i;
    return r;
  endfunction

  logic [31:0] rs1_fwd, rs2_fwd;

  assign rs1_fwd = fwd(ex_q.rs1_addr, ex_q.rs1_data);
  assign rs2_fwd = fwd(ex_q.rs2_addr, ex_q.rs2_data);

  assign ex_valid_o      = ex_q.valid;
  assign alu_op_o        = ex_q.alu_op;
  assign operand_a_o     = ex_q.op_a_sel ? ex_q.pc : rs1_fwd;
  assign operand_b_o     = ex_q.op_b_sel ? ex_q.imm : rs2_fwd;
  assign ex_store_data_o = rs2_fwd;
  assign ex_rd_addr_o    = ex_q.rd_addr;
  assign ex_rd_wren_o    = ex_q.rd_wren;
  assign ex_mem_rden_o   = ex_q.mem_rden;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX bundles are
// queued at drive time and compared one cycle later.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_i, hold_i;
  logic        id_valid_i;
  logic [3:0]  id_alu_op_i;
  logic [31:0] id_pc_i, id_imm_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_rd_wren_i, id_mem_rden_i;
  logic        id_op_a_sel_i, id_op_b_sel_i;
  logic [4:0]  mem_rd_addr_i;
  logic        mem_rd_wren_i;
  logic [31:0] mem_fwd_data_i;
  logic [4:0]  wb_rd_addr_i;
  logic        wb_rd_wren_i;
  logic [31:0] wb_data_i;
  logic        stall_o, ex_valid_o;
  logic [3:0]  alu_op_o;
  logic [31:0] operand_a_o, operand_b_o, ex_store_data_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_rd_wren_o, ex_mem_rden_o;

  id_ex_stage dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .hold_i          (hold_i),
    .id_valid_i      (id_valid_i),
    .id_alu_op_i     (id_alu_op_i),
    .id_pc_i         (id_pc_i),
    .id_imm_i        (id_imm_i),
    .id_rs1_data_i   (id_rs1_data_i),
    .id_rs2_data_i   (id_rs2_data_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .id_rd_addr_i    (id_rd_addr_i),
    .id_rd_wren_i    (id_rd_wren_i),
    .id_mem_rden_i   (id_mem_rden_i),
    .id_op_a_sel_i   (id_op_a_sel_i),
    .id_op_b_sel_i   (id_op_b_sel_i),
    .mem_rd_addr_i   (mem_rd_addr_i),
    .mem_rd_wren_i   (mem_rd_wren_i),
    .mem_fwd_data_i  (mem_fwd_data_i),
    .wb_rd_addr_i    (wb_rd_addr_i),
    .wb_rd_wren_i    (wb_rd_wren_i),
    .wb_data_i       (wb_data_i),
    .stall_o         (stall_o),
    .ex_valid_o      (ex_valid_o),
    .alu_op_o        (alu_op_o),
    .operand_a_o     (operand_a_o),
    .operand_b_o     (operand_b_o),
    .ex_store_data_o (ex_store_data_o),
    .ex_rd_addr_o    (ex_rd_addr_o),
    .ex_rd_wren_o    (ex_rd_wren_o),
    .ex_mem_rden_o   (ex_mem_rden_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        we;
    logic        re;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(
    input logic        v,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] st,
    input logic [4:0]  rd,
    input logic        we,
    input logic        re
  );
    exp_t e;
    e.v = v; e.op = op; e.a = a; e.b = b;
    e.st = st; e.rd = rd; e.we = we; e.re = re;
    return e;
  endfunction

  function automatic exp_t bub();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic id_set(
    input logic        v,
    input logic [3:0]  op,
    input logic [31:0] pc,
    input logic [31:0] imm,
    input logic [4:0]  r1a,
    input logic [31:0] r1d,
    input logic [4:0]  r2a,
    input logic [31:0] r2d,
    input logic [4:0]  rd,
    input logic        we,
    input logic        re,
    input logic        sa,
    input logic        sb
  );
    id_valid_i    = v;
    id_alu_op_i   = op;
    id_pc_i       = pc;
    id_imm_i      = imm;
    id_rs1_addr_i = r1a;
    id_rs1_data_i = r1d;
    id_rs2_addr_i = r2a;
    id_rs2_data_i = r2d;
    id_rd_addr_i  = rd;
    id_rd_wren_i  = we;
    id_mem_rden_i = re;
    id_op_a_sel_i = sa;
    id_op_b_sel_i = sb;
  endtask

  task automatic fwd_set(
    input logic [4:0]  ma,
    input logic        mw,
    input logic [31:0] md,
    input logic [4:0]  wa,
    input logic        ww,
    input logic [31:0] wd
  );
    mem_rd_addr_i  = ma;
    mem_rd_wren_i  = mw;
    mem_fwd_data_i = md;
    wb_rd_addr_i   = wa;
    wb_rd_wren_i   = ww;
    wb_data_i      = wd;
  endtask

  task automatic step(input string tag, input exp_t e);
    exp_t x;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb"}, 0, 1);
    end else begin
      x = sb_q.pop_front();
      chk({tag, "_v"},  {31'd0, ex_valid_o},    {31'd0, x.v});
      chk({tag, "_op"}, {28'd0, alu_op_o},      {28'd0, x.op});
      chk({tag, "_a"},  operand_a_o,            x.a);
      chk({tag, "_b"},  operand_b_o,            x.b);
      chk({tag, "_st"}, ex_store_data_o,        x.st);
      chk({tag, "_rd"}, {27'd0, ex_rd_addr_o},  {27'd0, x.rd});
      chk({tag, "_we"}, {31'd0, ex_rd_wren_o},  {31'd0, x.we});
      chk({tag, "_re"}, {31'd0, ex_mem_rden_o}, {31'd0, x.re});
    end
  endtask

  task automatic chk_stall(input string tag, input logic e);
    #1;
    chk(tag, {31'd0, stall_o}, {31'd0, e});
  endtask

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    hold_i  = 1'b0;
    id_set(1, 4'h5, 32'h40, 32'h8, 1, 32'h1, 2, 32'h2,
           3, 1, 1, 0, 0);
    fwd_set(0, 0, 0, 0, 0, 0);
    step("rst", bub());
    chk_stall("rst_stall", 0);

    // plain ADD, operands from the register file
    rst_ni = 1'b1;
    id_set(1, 4'h0, 32'h100, 32'h10, 1, 32'd5, 2, 32'd7,
           4, 1, 0, 0, 0);
    chk_stall("add_stall", 0);
    step("add", mk(1, 0, 5, 7, 7, 4, 1, 0));

    // PC/imm operands; store data still rs2
    id_set(1, 4'h3, 32'h200, 32'hFFFF_FFF0, 1, 32'd9,
           2, 32'd11, 4, 1, 0, 1, 1);
    step("sel", mk(1, 3, 32'h200, 32'hFFFF_FFF0, 11, 4, 1, 0));

    // EX/MEM wins over MEM/WB
    fwd_set(3, 1, 32'hAA, 3, 1, 32'hBB);
    id_set(1, 4'h1, 32'h300, 32'h0, 3, 32'h11, 0, 32'h0,
           6, 1, 0, 0, 0);
    step("fwd_mem", mk(1, 1, 32'hAA, 0, 0, 6, 1, 0));

    // hold 3 cycles; MEM/WB forwarding only now
    hold_i = 1'b1;
    fwd_set(0, 0, 0, 3, 1, 32'hBB);
    id_set(1, 4'h9, 32'h999, 32'h9, 7, 32'h77, 8, 32'h88,
           9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("hold", mk(1, 1, 32'hBB, 0, 0, 6, 1, 0));
    hold_i = 1'b0;

    // load x5 then a consumer of x5
    fwd_set(0, 0, 0, 0, 0, 0);
    id_set(1, 4'h0, 32'h400, 32'h4, 1, 32'h1000, 2, 32'd3,
           5, 1, 1, 0, 1);
    step("ld", mk(1, 0, 32'h1000, 4, 3, 5, 1, 1));
    id_set(1, 4'h0, 32'h404, 32'h0, 6, 32'd1, 5, 32'd0,
           7, 1, 0, 0, 0);
    chk_stall("lu_stall", 1);
    step("lu_bub", bub());
    fwd_set(0, 0, 0, 5, 1, 32'h5555);
    chk_stall("lu_nostall", 0);
    step("lu_use", mk(1, 0, 1, 32'h5555, 32'h5555, 7, 1, 0));

    // same hazard killed by a flush
    fwd_set(0, 0, 0, 0, 0, 0);
    id_set(1, 4'h0, 32'h500, 32'h8, 1, 32'h2000, 2, 32'd3,
           5, 1, 1, 0, 1);
    step("ld2", mk(1, 0, 32'h2000, 8, 3, 5, 1, 1));
    flush_i = 1'b1;
    id_set(1, 4'h0, 32'h504, 32'h0, 6, 32'd1, 5, 32'd0,
           7, 1, 0, 0, 0);
    chk_stall("fl_stall", 0);
    step("fl_bub", bub());
    flush_i = 1'b0;

    // load to x0 never stalls, x0 never forwarded
    id_set(1, 4'h0, 32'h600, 32'h0, 1, 32'h30, 2, 32'd3,
           0, 1, 1, 0, 1);
    step("ld0", mk(1, 0, 32'h30, 0, 3, 0, 1, 1));
    fwd_set(0, 1, 32'hBEEF, 0, 1, 32'hDEAD);
    id_set(1, 4'h2, 32'h604, 32'h0, 0, 32'h0, 2, 32'd3,
           9, 1, 0, 0, 0);
    chk_stall("x0_stall", 0);
    step("x0", mk(1, 2, 0, 3, 3, 9, 1, 0));

    // invalid ID slot captures a bubble
    fwd_set(0, 0, 0, 0, 0, 0);
    id_set(0, 4'h7, 32'h700, 32'h7, 1, 32'h7, 2, 32'h7,
           7, 1, 1, 1, 1);
    step("idle", bub());

    // reset during a pending stall
    id_set(1, 4'h0, 32'h800, 32'hC, 1, 32'h40, 2, 32'd3,
           5, 1, 1, 0, 1);
    step("ld3", mk(1, 0, 32'h40, 32'hC, 3, 5, 1, 1));
    id_set(1, 4'h0, 32'h804, 32'h0, 5, 32'd0, 2, 32'd3,
           7, 1, 0, 0, 0);
    chk_stall("rs_stall", 1);
    rst_ni = 1'b0;
    step("rs", bub());
    rst_ni = 1'b1;
    chk_stall("rs_nostall", 0);

    if (sb_q.size() != 0) chk("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and register addresses at 5 bits.
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  in  1  reset, synchronous, active-low.
REQ-004 flush_i  in  1  branch/jump redirect; the instruction in ID is discarded.
REQ-005 hold_i  in  1  downstream freeze; EX register keeps its contents.
REQ-006 id_valid_i  in  1  ID holds a real instruction.
REQ-007 id_alu_op_i  in  4  ALU operation code for the instruction in ID.
REQ-008 id_pc_i, id_imm_i  in  32 each  PC and sign-extended immediate.
REQ-009 id_rs1_data_i, id_rs2_data_i  in  32 each  register-file read data.
REQ-010 id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  5 each  source and destination indices.
REQ-011 id_rd_wren_i, id_mem_rden_i  in  1 each  writes rd; is a load.
REQ-012 id_op_a_sel_i, id_op_b_sel_i  in  1 each  A: 0=rs1, 1=PC; B: 0=rs2, 1=imm.
REQ-013 mem_rd_addr_i, mem_rd_wren_i, mem_fwd_data_i  in  5/1/32  EX/MEM destination and ALU result.
REQ-014 wb_rd_addr_i, wb_rd_wren_i, wb_data_i  in  5/1/32  MEM/WB destination and write-back data.
REQ-015 stall_o  out  1  load-use stall request to PC and IF/ID.
REQ-016 ex_valid_o  out  1  EX holds a real instruction.
REQ-017 alu_op_o, operand_a_o, operand_b_o  out  4/32/32  ALU inputs.
REQ-018 ex_store_data_o  out  32  forwarded rs2 value for stores.
REQ-019 ex_rd_addr_o, ex_rd_wren_o, ex_mem_rden_o  out  5/1/1  registered destination controls.

Function
REQ-020 The EX register SHALL capture valid, alu_op, pc, imm, rs1/rs2 data and addresses, rd_addr, rd_wren, mem_rden, and both operand selects; outputs follow the capture with 1-cycle latency.
REQ-021 Capture-time write-through: if wb_rd_wren_i=1, wb_rd_addr_i!=0 and wb_rd_addr_i matches id_rsN_addr_i, the block SHALL store wb_data_i instead of id_rsN_data_i.
REQ-022 Hazard: stall_o=1 combinationally when ex_valid_o=1, ex_mem_rden_o=1, ex_rd_addr_o!=0, id_valid_i=1, flush_i=0, hold_i=0, and ex_rd_addr_o equals id_rs1_addr_i or id_rs2_addr_i; otherwise stall_o=0.
REQ-023 Bubble: the register SHALL load valid=0, rd_wren=0, mem_rden=0, alu_op=0 and all data fields=0.
REQ-024 Update priority per edge: reset, then flush_i (bubble), then hold_i (keep contents), then stall_o (bubble), then normal capture.
REQ-025 When id_valid_i=0 the block SHALL capture a bubble.
REQ-026 Forwarding for each source SHALL be combinational on registered state: EX/MEM match (wren=1, addr!=0, addr equal) first, then MEM/WB match, else the registered value.
REQ-027 Register x0 SHALL never be forwarded; a source address of 0 SHALL always yield the registered value.
REQ-028 operand_a_o SHALL be the registered PC when op_a_sel=1, else forwarded rs1; operand_b_o SHALL be the registered imm when op_b_sel=1, else forwarded rs2.
REQ-029 ex_store_data_o SHALL always be forwarded rs2, independent of op_b_sel.
REQ-030 A flush or a hold SHALL override a pending load-use hazard in the same cycle; stall_o SHALL be 0 in those cycles.

Reset
REQ-031 With rst_ni=0 at a clock edge, every register SHALL clear to 0, giving bubble state; all outputs then read 0, including stall_o. Reset applied mid-stall SHALL cancel the stall on the next cycle.

Verification
REQ-032 ADD with x1=5 in ID and op selects 0/0 -> next cycle alu_op_o=0, operands equal the two register values, ex_valid_o=1.
REQ-033 EX/MEM rd=x3 with data 0xAA and MEM/WB rd=x3 with data 0xBB; EX reads rs1=x3 -> operand_a_o=0xAA; with MEM/WB only -> 0xBB.
REQ-034 Load to x5 in EX and ID uses rs2=x5 -> stall_o=1 for one cycle, a bubble enters EX, and the consumer then sees WB forwarding.
REQ-035 Same hazard with flush_i=1 -> stall_o=0 and a bubble in EX; rd=x0 load with rs1=x0 -> no stall and operand=0.
REQ-036 hold_i=1 for 3 cycles -> all outputs stable; rst_ni=0 mid-operation -> all outputs 0 on the next cycle.
